// File: rtl/buzzer_note_player.sv
// Plays one note at a time: latches a note code, reads its divider preset from the
// frequency ROM, toggles the buzzer for the requested beats, then holds a silent gap.
module buzzer_note_player #(
  parameter int ROM_WIDTH   = 16,
  parameter int TONE_DIV    = 16,
  parameter int BEAT_CYCLES = 6250000,
  parameter int GAP_CYCLES  = 625000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [11:0]          note_code,
  input  logic [3:0]           note_beats,
  input  logic                 note_valid,
  output logic                 note_ready,
  output logic [11:0]          rom_note_code,
  input  logic [ROM_WIDTH-1:0] origin,
  output logic                 buzz,
  output logic                 busy,
  output logic                 note_done
);

  localparam int PRE_W    = (TONE_DIV > 1) ? $clog2(TONE_DIV) : 1;
  localparam int BEAT_W   = (BEAT_CYCLES > 1) ? $clog2(BEAT_CYCLES) : 1;
  localparam int GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

  localparam logic [PRE_W-1:0]  PRE_LAST_C  = PRE_W'(TONE_DIV - 1);
  localparam logic [BEAT_W-1:0] BEAT_LAST_C = BEAT_W'(BEAT_CYCLES - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST_C  = GAP_W'(GAP_LAST);
  localparam logic [13:0]       TONE_TOP    = 14'h3fff;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    PLAY = 2'd2,
    GAP  = 2'd3
  } state_t;

  state_t            state;
  logic [13:0]       reload;
  logic              silent;
  logic [13:0]       tone_cnt;
  logic [PRE_W-1:0]  pre_cnt;
  logic [BEAT_W-1:0] beat_cnt;
  logic [GAP_W-1:0]  gap_cnt;
  logic [3:0]        beats_left;

  assign note_ready = (state == IDLE);
  assign busy       = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      rom_note_code <= 12'h000;
      buzz          <= 1'b0;
      note_done     <= 1'b0;
      reload        <= '0;
      silent        <= 1'b0;
      tone_cnt      <= '0;
      pre_cnt       <= '0;
      beat_cnt      <= '0;
      gap_cnt       <= '0;
      beats_left    <= '0;
    end else begin
      note_done <= 1'b0;
      unique case (state)
        IDLE: begin
          buzz <= 1'b0;
          if (note_valid) begin
            rom_note_code <= note_code;
            beats_left    <= (note_beats == 4'd0) ? 4'd1 : note_beats;
            state         <= LOAD;
          end
        end

        LOAD: begin
          // Presets at or above the tone counter's top encode a rest.
          reload   <= origin[13:0];
          silent   <= (origin >= ROM_WIDTH'(16383));
          tone_cnt <= origin[13:0];
          pre_cnt  <= '0;
          beat_cnt <= '0;
          buzz     <= 1'b0;
          state    <= PLAY;
        end

        PLAY: begin
          if (pre_cnt == PRE_LAST_C) begin
            pre_cnt <= '0;
            if (tone_cnt == TONE_TOP) begin
              tone_cnt <= reload;
              if (!silent) buzz <= ~buzz;
            end else begin
              tone_cnt <= tone_cnt + 14'd1;
            end
          end else begin
            pre_cnt <= pre_cnt + PRE_W'(1);
          end

          // NOTE: non-blocking assignments let the later buzz <= 0 below override a
          // same-cycle toggle, so the pin is always low once the note ends.
          if (beat_cnt == BEAT_LAST_C) begin
            beat_cnt   <= '0;
            beats_left <= beats_left - 4'd1;
            if (beats_left == 4'd1) begin
              buzz    <= 1'b0;
              gap_cnt <= '0;
              if (GAP_CYCLES == 0) begin
                state     <= IDLE;
                note_done <= 1'b1;
              end else begin
                state <= GAP;
              end
            end
          end else begin
            beat_cnt <= beat_cnt + BEAT_W'(1);
          end
        end

        GAP: begin
          buzz <= 1'b0;
          if (gap_cnt == GAP_LAST_C) begin
            state     <= IDLE;
            note_done <= 1'b1;
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
